i2s_tx: RTL and testbench
=========================

# i2s_tx

I2S transmitter: accepts left/right PCM sample pairs over a valid/ready handshake and serialises them as an I2S stream (`ws` word select, `sd` serial data, MSB first, one-bit delay after `ws` transition). It is the source end of the I2S link that the receiver top-level (`sd1`/`sd2`, `ws`, `sck`) consumes. It drives on-chip loopback and bench stimulus. The integrating top clocks it from the inverted bit clock, so `ws`/`sd` change on the falling edge of the receiver's `sck`.

## Interface
- `WIDTH`, 16: sample width in bits.
- `SLOT`, 16: bit clocks per channel slot, SLOT >= WIDTH; frame = 2*SLOT bits.

- `sck`  in  1  bit clock; all registers update on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run request; sampled every cycle.
- `left_in`  in  WIDTH  left sample.
- `right_in`  in  WIDTH  right sample.
- `in_valid`  in  1  sample pair valid.
- `in_ready`  out  1  pair accepted on an edge where `in_valid && in_ready`.
- `ws`  out  1  word select, 0 = left, 1 = right.
- `sd`  out  1  serial data.
- `frame_start`  out  1  high during the cycle presenting the left MSB (cnt = 0).
- `underrun`  out  1  one-cycle pulse, cnt = 0 of a frame sent as zeros.
- `busy`  out  1  state == RUN.

## Operation
- States: IDLE, RUN. Bit counter `cnt` runs 0..2*SLOT-1 and wraps.
- One-entry hold buffer plus a 2*SLOT-bit frame shift register. `in_ready = !buf_full`, forced 0 while `rst` is high.
- IDLE: `ws`=0, `sd`=0, `cnt`=2*SLOT-1. If `en`=1, go to RUN. The first RUN cycle presents cnt = 2*SLOT-1.
- RUN, cycle with cnt = c:
  - `ws` = 1 iff SLOT-1 <= c <= 2*SLOT-2.
  - Left slot is c in 0..SLOT-1. Position j = c; `sd` = left[WIDTH-1-j] for j < WIDTH, else 0.
  - Right slot is c in SLOT..2*SLOT-1. Position j = c-SLOT; same rule applied to `right`.
- Frame boundary is the edge ending cnt = 2*SLOT-1:
  - `en`=0: go to IDLE. No transfer; the buffer is retained.
  - `buf_full`: buffer moves to the shift register and the buffer empties. A new pair may be accepted on the same edge only if the buffer was empty before the edge; `in_ready` already reflects this.
  - Buffer empty and `in_valid`: input bypasses straight into the shift register.
  - Buffer empty and no `in_valid`: shift register loads zeros; `underrun` pulses at the next cnt = 0.
- `en` dropped mid-frame: the frame always completes through cnt = 2*SLOT-1, then IDLE.
- Acceptance while not at a boundary fills the buffer.

## Timing
- Reset values: `ws`=0, `sd`=0, `in_ready`=0 during reset, `frame_start`=0, `underrun`=0, `busy`=0. Buffer empty, state IDLE.
- `en` rising in IDLE: one cycle at cnt = 2*SLOT-1 (`ws`=0, `sd`=0), then left MSB.
- Buffered pair: its left MSB appears in the cycle after the next boundary.
- Bypass pair: its left MSB appears in the cycle after acceptance.
- Reset mid-frame: the next cycle is IDLE with reset outputs; in-flight and buffered samples are discarded.
- `ws` period is exactly 2*SLOT cycles. Frames in RUN are gapless.

## Structure
- Package `i2s_pkg`:
  - state enum {IDLE, RUN}
  - function `cnt_w(SLOT) = $clog2(2*SLOT)`
  - localparam `FRAME_BITS = 2*SLOT`
- Sub-module `i2s_hold_buf`: one-entry valid/ready buffer with bypass output and `take` strobe.
- Top `i2s_tx` holds the FSM, counter and shift register.

## Test plan
- Reset: `rst` held 2 cycles mid-RUN -> next cycle `ws`=0, `sd`=0, `busy`=0; `in_ready` 0 during reset, 1 after; a buffered pair is never transmitted.
- Single frame (WIDTH=SLOT=16): preload L=16'hA5C3, R=16'h0F01, then `en`=1:
  - one idle-value cycle, then `sd` = 1010010111000011 followed by 0000111100000001;
  - `ws` rises on the 16th left bit and falls on the 16th right bit;
  - `frame_start` pulses once.
- Underrun: `en`=1 with no `in_valid` -> all-zero frames, `underrun` pulse at each cnt = 0, `ws` period 32.
- Back-to-back: three pairs with `in_valid` held high -> `in_ready` low while the buffer is full; three contiguous frames, order preserved, no underrun.
- Bypass: buffer empty, pair valid only during cnt = 31 -> its MSB appears in the next cycle, no `underrun`.
- Stop/padding (WIDTH=12, SLOT=16): `en` dropped at cnt = 5 -> frame completes, IDLE after cnt = 31; slot bits 12..15 are 0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and sizing helpers for the I2S transmitter.
// The default sizes give a 16-bit sample in a 16-bit slot.
package i2s_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_SLOT   = 16;
  localparam int FRAME_BITS = 2 * DEF_SLOT;

  // Width of the bit counter that spans one stereo frame.
  function automatic int cnt_w(input int slot);
    return $clog2(2 * slot);
  endfunction

endpackage

// File: rtl/i2s_hold_buf.sv
// One-entry valid/ready holding buffer for a left/right sample pair.
// When empty, the incoming pair is presented straight through as a bypass.
module i2s_hold_buf #(
  parameter int WIDTH = 16
) (
  input  logic             sck,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] left_in,
  input  logic [WIDTH-1:0] right_in,
  output logic             in_ready,
  input  logic             take,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_left,
  output logic [WIDTH-1:0] out_right
);

  logic             full;
  logic [WIDTH-1:0] hold_left;
  logic [WIDTH-1:0] hold_right;
  logic             accept;

  assign in_ready  = !full && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = full || in_valid;
  assign out_left  = full ? hold_left  : left_in;
  assign out_right = full ? hold_right : right_in;

  // An accept on a take edge can only happen while empty, so it is a bypass.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sck) begin
    if (rst)         full <= 1'b0;
    else if (take)   full <= 1'b0;
    else if (accept) full <= 1'b1;
  end

  // NOTE: the sample registers carry no reset; full alone says whether they hold anything.
  always_ff @(posedge sck) begin
    if (accept && !take) begin
      hold_left  <= left_in;
      hold_right <= right_in;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: frames buffered sample pairs into a gapless ws/sd stream,
// MSB first with the one-bit delay after each ws transition.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLOT  = DEF_SLOT
) (
  input  logic             sck,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] left_in,
  input  logic [WIDTH-1:0] right_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ws,
  output logic             sd,
  output logic             frame_start,
  output logic             underrun,
  output logic             busy
);

  localparam int FB = 2 * SLOT;
  localparam int CW = cnt_w(SLOT);
  localparam logic [CW-1:0] LAST  = CW'(FB - 1);
  localparam logic [CW-1:0] WS_LO = CW'(SLOT - 1);
  localparam logic [CW-1:0] WS_HI = CW'(FB - 2);

  state_e           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [FB-1:0]    shreg, shreg_nxt;
  logic             underrun_q, underrun_nxt;

  logic             take;
  logic             hb_valid;
  logic [WIDTH-1:0] hb_left, hb_right;
  logic [SLOT-1:0]  left_slot, right_slot;

  assign take = (state == RUN) && (cnt == LAST) && en;

  i2s_hold_buf #(.WIDTH(WIDTH)) u_hold_buf (
    .sck       (sck),
    .rst       (rst),
    .in_valid  (in_valid),
    .left_in   (left_in),
    .right_in  (right_in),
    .in_ready  (in_ready),
    .take      (take),
    .out_valid (hb_valid),
    .out_left  (hb_left),
    .out_right (hb_right)
  );

  // Samples sit at the top of their slot; unused trailing slot bits are zero.
  always_comb begin
    left_slot                    = '0;
    right_slot                   = '0;
    left_slot[SLOT-1 -: WIDTH]   = hb_left;
    right_slot[SLOT-1 -: WIDTH]  = hb_right;
  end

  // NOTE: combinational blocks assign every output a default first, so no latch is inferred.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    shreg_nxt    = shreg;
    underrun_nxt = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt   = LAST;
        shreg_nxt = '0;
        if (en) state_nxt = RUN;
      end
      RUN: begin
        if (cnt == LAST) begin
          cnt_nxt = '0;
          if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = LAST;
            shreg_nxt = '0;
          end else if (hb_valid) begin
            shreg_nxt = {left_slot, right_slot};
          end else begin
            shreg_nxt    = '0;
            underrun_nxt = 1'b1;
          end
        end else begin
          cnt_nxt   = cnt + 1'b1;
          shreg_nxt = {shreg[FB-2:0], 1'b0};
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sck) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= LAST;
      shreg      <= '0;
      underrun_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shreg      <= shreg_nxt;
      underrun_q <= underrun_nxt;
    end
  end

  // ws leads the slot by one bit, giving the I2S one-bit data delay.
  assign busy        = (state == RUN);
  assign ws          = busy && (cnt >= WS_LO) && (cnt <= WS_HI);
  assign sd          = busy && shreg[FB-1];
  assign frame_start = busy && (cnt == '0);
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed self-checking bench for i2s_tx: a 16/16 instance for framing,
// flow control and reset, and a 12/16 instance for stop and slot padding.
module tb_i2s_tx;

  logic        sck = 1'b0;
  logic        rst, en, in_valid;
  logic [15:0] left_in, right_in;
  logic        in_ready, ws, sd, frame_start, underrun, busy;

  logic        rst2, en2, in_valid2;
  logic [11:0] left_in2, right_in2;
  logic        in_ready2, ws2, sd2, frame_start2, underrun2, busy2;

  int checks   = 0;
  int failures = 0;

  always #5 sck = ~sck;

  i2s_tx #(.WIDTH(16), .SLOT(16)) u_dut (
    .sck(sck), .rst(rst), .en(en), .left_in(left_in), .right_in(right_in),
    .in_valid(in_valid), .in_ready(in_ready), .ws(ws), .sd(sd),
    .frame_start(frame_start), .underrun(underrun), .busy(busy)
  );

  i2s_tx #(.WIDTH(12), .SLOT(16)) u_dut12 (
    .sck(sck), .rst(rst2), .en(en2), .left_in(left_in2), .right_in(right_in2),
    .in_valid(in_valid2), .in_ready(in_ready2), .ws(ws2), .sd(sd2),
    .frame_start(frame_start2), .underrun(underrun2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled and inputs changed on the falling edge.
  task automatic step();
    @(negedge sck);
  endtask

  logic [31:0] sdv, wsv;
  logic [63:0] sd64, ws64, ur64;
  logic [95:0] sd96;
  logic [15:0] pl [3];
  logic [15:0] pr [3];
  int fs_cnt, ur_cnt, nrdy_cnt, idx;
  logic hs, rdy_c0;

  initial begin
    rst = 1; en = 0; in_valid = 0; left_in = '0; right_in = '0;
    rst2 = 1; en2 = 0; in_valid2 = 0; left_in2 = '0; right_in2 = '0;
    pl[0] = 16'h1111; pr[0] = 16'h2222;
    pl[1] = 16'h3333; pr[1] = 16'h4444;
    pl[2] = 16'h5555; pr[2] = 16'h6666;

    // Reset values
    step(); step();
    check("rst_ws", ws, 0);
    check("rst_sd", sd, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_underrun", underrun, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 0;
    step();
    check("post_rst_in_ready", in_ready, 1);

    // Single frame from a preloaded pair
    left_in = 16'hA5C3; right_in = 16'h0F01; in_valid = 1;
    step();
    in_valid = 0;
    check("preload_full_ready", in_ready, 0);
    en = 1;
    step();
    check("idle_cycle_busy", busy, 1);
    check("idle_cycle_ws", ws, 0);
    check("idle_cycle_sd", sd, 0);
    check("idle_cycle_fs", frame_start, 0);
    sdv = '0; wsv = '0; fs_cnt = 0; ur_cnt = 0; rdy_c0 = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      sdv = {sdv[30:0], sd};
      wsv = {wsv[30:0], ws};
      fs_cnt += int'(frame_start);
      ur_cnt += int'(underrun);
      if (i == 0) rdy_c0 = in_ready;
    end
    check("single_sd", sdv, 32'hA5C3_0F01);
    check("single_ws", wsv, 32'h0001_FFFE);
    check("single_fs_count", fs_cnt, 1);
    check("single_underrun", ur_cnt, 0);
    check("single_ready_c0", rdy_c0, 1);

    // Underrun frames
    sd64 = '0; ws64 = '0; ur64 = '0; fs_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      sd64 = {sd64[62:0], sd};
      ws64 = {ws64[62:0], ws};
      ur64 = {ur64[62:0], underrun};
      fs_cnt += int'(frame_start);
    end
    check("underrun_sd", sd64, 64'h0);
    check("underrun_ws_period", ws64, 64'h0001_FFFE_0001_FFFE);
    check("underrun_pulses", ur64, 64'h8000_0000_8000_0000);
    check("underrun_fs_count", fs_cnt, 2);

    // Reset mid-RUN discards a buffered pair
    step();
    left_in = 16'hFFFF; right_in = 16'hFFFF; in_valid = 1;
    step();
    in_valid = 0;
    check("mid_buffered_ready", in_ready, 0);
    rst = 1;
    step();
    check("midrst_ws", ws, 0);
    check("midrst_sd", sd, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    step();
    rst = 0;
    step();
    check("after_rst_ready", in_ready, 1);
    check("after_rst_busy", busy, 1);
    sdv = '0; ur_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      sdv = {sdv[30:0], sd};
      ur_cnt += int'(underrun);
    end
    check("discarded_pair_sd", sdv, 32'h0);
    check("discarded_pair_underrun", ur_cnt, 1);

    // Back-to-back pairs with in_valid held high
    idx = 0; left_in = pl[0]; right_in = pr[0]; in_valid = 1;
    sd96 = '0; ur_cnt = 0; fs_cnt = 0; nrdy_cnt = 0;
    for (int i = 0; i < 96; i++) begin
      hs = in_valid && in_ready;
      step();
      if (hs) begin
        idx++;
        if (idx < 3) begin
          left_in = pl[idx]; right_in = pr[idx];
        end else begin
          in_valid = 0;
        end
      end
      sd96 = {sd96[94:0], sd};
      ur_cnt += int'(underrun);
      fs_cnt += int'(frame_start);
      nrdy_cnt += int'(!in_ready);
    end
    check("b2b_sd", sd96, 96'h1111_2222_3333_4444_5555_6666);
    check("b2b_underrun", ur_cnt, 0);
    check("b2b_fs_count", fs_cnt, 3);
    check("b2b_not_ready_cycles", nrdy_cnt, 62);
    check("b2b_accepted", idx, 3);

    // Bypass: pair valid only during cnt = 31 of an underrun frame
    ur_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      ur_cnt += int'(underrun);
    end
    check("filler_underrun", ur_cnt, 1);
    left_in = 16'hABCD; right_in = 16'h1234; in_valid = 1;
    step();
    in_valid = 0;
    check("bypass_msb", sd, 1);
    check("bypass_underrun", underrun, 0);
    check("bypass_fs", frame_start, 1);
    sdv = {31'h0, sd};
    for (int i = 0; i < 31; i++) begin
      step();
      sdv = {sdv[30:0], sd};
    end
    check("bypass_frame", sdv, 32'hABCD_1234);

    // Stop mid-frame and slot padding on the 12-bit instance
    rst2 = 0; left_in2 = 12'hABC; right_in2 = 12'h123; in_valid2 = 1;
    step();
    in_valid2 = 0; en2 = 1;
    step();
    check("w12_idle_cycle_busy", busy2, 1);
    check("w12_idle_cycle_sd", sd2, 0);
    sdv = '0;
    for (int i = 0; i < 32; i++) begin
      step();
      sdv = {sdv[30:0], sd2};
      if (i == 5) en2 = 0;
    end
    check("w12_busy_at_c31", busy2, 1);
    check("w12_frame", sdv, 32'hABC0_1230);
    check("w12_padding", sdv & 32'h000F_000F, 32'h0);
    step();
    check("w12_stop_busy", busy2, 0);
    check("w12_stop_ws", ws2, 0);
    check("w12_stop_sd", sd2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
